// File: rtl/educell_syndromeacc_pkg.sv
// Shared encodings for the EDU cell syndrome accumulator: Pauli values,
// cell state codes and accumulator FSM codes.
package educell_syndromeacc_pkg;

  localparam logic [1:0] PP_I = 2'b00;
  localparam logic [1:0] PP_X = 2'b01;
  localparam logic [1:0] PP_Z = 2'b10;
  localparam logic [1:0] PP_Y = 2'b11;

  localparam logic [2:0] EDUCELL_IDLE     = 3'd0;
  localparam logic [2:0] EDUCELL_ACTIVE   = 3'd1;
  localparam logic [2:0] EDUCELL_BOUNDARY = 3'd2;
  localparam logic [2:0] EDUCELL_FAULT    = 3'd3;

  typedef enum logic [1:0] {
    SYNACC_IDLE  = 2'd0,
    SYNACC_ACCUM = 2'd1,
    SYNACC_DONE  = 2'd2
  } synacc_state_e;

endpackage

// File: rtl/educell_syndrome_merge.sv
// Folds the six neighbour Pauli syndromes into one value plus an activity flag.
// Latency: combinational. Backpressure: none; boundary cells absorb everything.
module educell_syndrome_merge
  import educell_syndromeacc_pkg::*;
(
  input  logic [1:0] syn_nw,
  input  logic [1:0] syn_ne,
  input  logic [1:0] syn_sw,
  input  logic [1:0] syn_se,
  input  logic [1:0] syn_n,
  input  logic [1:0] syn_s,
  input  logic       boundary,
  output logic [1:0] merged,
  output logic       hit
);

  logic [1:0] xor_all;
  logic       any_active;

  // Phase is ignored, so Pauli composition reduces to XOR of the encodings.
  assign xor_all    = syn_nw ^ syn_ne ^ syn_sw ^ syn_se ^ syn_n ^ syn_s;
  assign any_active = (syn_nw != PP_I) || (syn_ne != PP_I) || (syn_sw != PP_I) ||
                      (syn_se != PP_I) || (syn_n  != PP_I) || (syn_s  != PP_I);

  assign merged = boundary ? PP_I : xor_all;
  assign hit    = boundary ? 1'b0 : any_active;

endmodule

// File: rtl/educell_syndromeacc.sv
// Per-cell syndrome accumulator; result offered via valid/ack once the mesh is quiet.
// Latency: inputs reach acc next cycle; valid after QUIET_CYCLES quiet cycles. Holds result until ack.
// Optional hit counter: EDUCELL_SYNACC_HITCNT_EN (undefined -> hit_cnt tied to 0).
module educell_syndromeacc
  import educell_syndromeacc_pkg::*;
#(
  parameter int QUIET_CYCLES = 4,
  parameter int CNT_WIDTH    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           state,
  input  logic                 round_start,
  input  logic [1:0]           syndrome_in_nw,
  input  logic [1:0]           syndrome_in_ne,
  input  logic [1:0]           syndrome_in_sw,
  input  logic [1:0]           syndrome_in_se,
  input  logic [1:0]           syndrome_in_n,
  input  logic [1:0]           syndrome_in_s,
  input  logic                 correction_ack,
  output logic [1:0]           correction_out,
  output logic                 correction_valid,
  output logic                 syndrome_pending,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] hit_cnt
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);

  synacc_state_e fsm_q, fsm_d;
  logic [1:0]    acc_q;
  logic [QW-1:0] quiet_q;
  logic [1:0]    merged;
  logic          hit;
  logic          quiet_done;

  educell_syndrome_merge u_merge (
    .syn_nw   (syndrome_in_nw),
    .syn_ne   (syndrome_in_ne),
    .syn_sw   (syndrome_in_sw),
    .syn_se   (syndrome_in_se),
    .syn_n    (syndrome_in_n),
    .syn_s    (syndrome_in_s),
    .boundary (state == EDUCELL_BOUNDARY),
    .merged   (merged),
    .hit      (hit)
  );

  assign quiet_done = !hit && (quiet_q == QW'(QUIET_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm_q <= SYNACC_IDLE;
    else        fsm_q <= fsm_d;
  end

  // round_start outranks both quiet completion and ack.
  always_comb begin
    fsm_d = fsm_q;
    if (round_start) begin
      fsm_d = SYNACC_ACCUM;
    end else begin
      case (fsm_q)
        SYNACC_IDLE:  fsm_d = SYNACC_IDLE;
        SYNACC_ACCUM: if (quiet_done) fsm_d = SYNACC_DONE;
        SYNACC_DONE:  if (correction_ack) fsm_d = SYNACC_IDLE;
        default:      fsm_d = SYNACC_IDLE;
      endcase
    end
  end

  always_comb begin
    busy             = (fsm_q == SYNACC_ACCUM);
    correction_valid = (fsm_q == SYNACC_DONE);
    correction_out   = acc_q;
    syndrome_pending = (acc_q != PP_I);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= PP_I;
      quiet_q <= '0;
    end else if (round_start) begin
      acc_q   <= PP_I;
      quiet_q <= '0;
    end else if (fsm_q == SYNACC_ACCUM) begin
      acc_q   <= acc_q ^ merged;
      quiet_q <= hit ? '0 : quiet_q + QW'(1);
    end
  end

`ifdef EDUCELL_SYNACC_HITCNT_EN
  logic [CNT_WIDTH-1:0] hit_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q <= '0;
    end else if (round_start) begin
      hit_cnt_q <= '0;
    end else if ((fsm_q == SYNACC_ACCUM) && hit && (hit_cnt_q != '1)) begin
      hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign hit_cnt = hit_cnt_q;
`else
  assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_educell_syndromeacc.sv
// Directed self-checking bench for educell_syndromeacc (QUIET_CYCLES=4, CNT_WIDTH=4).
module tb_educell_syndromeacc;
  import educell_syndromeacc_pkg::*;

`ifdef EDUCELL_SYNACC_HITCNT_EN
  localparam logic [3:0] EXP_ONE = 4'd1;
  localparam logic [3:0] EXP_SAT = 4'd15;
`else
  localparam logic [3:0] EXP_ONE = 4'd0;
  localparam logic [3:0] EXP_SAT = 4'd0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state;
  logic       round_start;
  logic [1:0] nw, ne, sw, se, n, s;
  logic       correction_ack;
  logic [1:0] correction_out;
  logic       correction_valid;
  logic       syndrome_pending;
  logic       busy;
  logic [3:0] hit_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  educell_syndromeacc #(.QUIET_CYCLES(4), .CNT_WIDTH(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .state            (state),
    .round_start      (round_start),
    .syndrome_in_nw   (nw),
    .syndrome_in_ne   (ne),
    .syndrome_in_sw   (sw),
    .syndrome_in_se   (se),
    .syndrome_in_n    (n),
    .syndrome_in_s    (s),
    .correction_ack   (correction_ack),
    .correction_out   (correction_out),
    .correction_valid (correction_valid),
    .syndrome_pending (syndrome_pending),
    .busy             (busy),
    .hit_cnt          (hit_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_syn();
    nw = PP_I; ne = PP_I; sw = PP_I; se = PP_I; n = PP_I; s = PP_I;
  endtask

  task automatic start_round();
    round_start = 1'b1;
    tick();
    round_start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({correction_out, correction_valid, syndrome_pending, busy, hit_cnt} !== 9'd0) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b",
               {correction_out, correction_valid, syndrome_pending, busy, hit_cnt}, 9'd0);
    end
    rst_n = 1'b1;
    start_round();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_start got=%b exp=1", busy);
    end
    n = PP_Z;
    tick();
    clear_syn();
    checks++;
    if (syndrome_pending !== 1'b1) begin
      failures++;
      $display("FAIL pending_before_reset got=%b exp=1", syndrome_pending);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({correction_out, correction_valid, syndrome_pending, busy, hit_cnt} !== 9'd0) begin
      failures++;
      $display("FAIL async_reset got=%b exp=%b",
               {correction_out, correction_valid, syndrome_pending, busy, hit_cnt}, 9'd0);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({busy, correction_valid} !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_release got=%b exp=00", {busy, correction_valid});
    end
  endtask

  task automatic test_single_hit();
    start_round();
    n = PP_Z;
    tick();
    clear_syn();
    checks++;
    if (syndrome_pending !== 1'b1) begin
      failures++;
      $display("FAIL single_pending got=%b exp=1", syndrome_pending);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (correction_valid !== 1'b0) begin
        failures++;
        $display("FAIL single_early_valid cycle=%0d got=%b exp=0", i, correction_valid);
      end
    end
    tick();
    checks++;
    if ({correction_valid, correction_out, hit_cnt} !== {1'b1, PP_Z, EXP_ONE}) begin
      failures++;
      $display("FAIL single_done got=%b exp=%b",
               {correction_valid, correction_out, hit_cnt}, {1'b1, PP_Z, EXP_ONE});
    end
    correction_ack = 1'b1;
    tick();
    correction_ack = 1'b0;
    checks++;
    if ({correction_valid, busy, syndrome_pending} !== 3'b001) begin
      failures++;
      $display("FAIL single_ack got=%b exp=001", {correction_valid, busy, syndrome_pending});
    end
  endtask

  task automatic test_cancellation();
    start_round();
    tick();
    tick();
    nw = PP_X;
    se = PP_X;
    tick();
    clear_syn();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (correction_valid !== 1'b0) begin
        failures++;
        $display("FAIL cancel_early_valid cycle=%0d got=%b exp=0", i, correction_valid);
      end
    end
    tick();
    checks++;
    if ({correction_valid, correction_out, syndrome_pending, hit_cnt} !== {1'b1, PP_I, 1'b0, EXP_ONE}) begin
      failures++;
      $display("FAIL cancel_done got=%b exp=%b",
               {correction_valid, correction_out, syndrome_pending, hit_cnt},
               {1'b1, PP_I, 1'b0, EXP_ONE});
    end
    correction_ack = 1'b1;
    tick();
    correction_ack = 1'b0;
  endtask

  task automatic test_boundary();
    state = EDUCELL_BOUNDARY;
    s = PP_Y;
    start_round();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({correction_valid, syndrome_pending} !== 2'b00) begin
        failures++;
        $display("FAIL boundary_early cycle=%0d got=%b exp=00", i, {correction_valid, syndrome_pending});
      end
    end
    tick();
    checks++;
    if ({correction_valid, correction_out, hit_cnt} !== {1'b1, PP_I, 4'd0}) begin
      failures++;
      $display("FAIL boundary_done got=%b exp=%b",
               {correction_valid, correction_out, hit_cnt}, {1'b1, PP_I, 4'd0});
    end
    correction_ack = 1'b1;
    tick();
    correction_ack = 1'b0;
    clear_syn();
    state = EDUCELL_ACTIVE;
  endtask

  task automatic test_handshake_priority();
    start_round();
    correction_ack = 1'b1;
    n = PP_X;
    s = PP_Z;
    tick();
    correction_ack = 1'b0;
    clear_syn();
    checks++;
    if ({busy, correction_out} !== {1'b1, PP_Y}) begin
      failures++;
      $display("FAIL ack_outside_done got=%b exp=%b", {busy, correction_out}, {1'b1, PP_Y});
    end
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({correction_valid, correction_out} !== {1'b1, PP_Y}) begin
        failures++;
        $display("FAIL done_hold cycle=%0d got=%b exp=%b", i, {correction_valid, correction_out}, {1'b1, PP_Y});
      end
      tick();
    end
    correction_ack = 1'b1;
    round_start = 1'b1;
    tick();
    correction_ack = 1'b0;
    round_start = 1'b0;
    checks++;
    if ({busy, correction_valid, syndrome_pending, correction_out} !== {3'b100, PP_I}) begin
      failures++;
      $display("FAIL start_beats_ack got=%b exp=%b",
               {busy, correction_valid, syndrome_pending, correction_out}, {3'b100, PP_I});
    end
  endtask

  task automatic test_saturation();
    start_round();
    nw = PP_Y;
    for (int i = 0; i < 20; i++) tick();
    clear_syn();
    checks++;
    if ({busy, hit_cnt} !== {1'b1, EXP_SAT}) begin
      failures++;
      $display("FAIL hit_saturate got=%b exp=%b", {busy, hit_cnt}, {1'b1, EXP_SAT});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    state = EDUCELL_ACTIVE;
    round_start = 1'b0;
    correction_ack = 1'b0;
    clear_syn();
    test_reset();
    test_single_hit();
    test_cancellation();
    test_boundary();
    test_handshake_priority();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
